// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with registered outputs and valid/ready handshakes.
//
// Single-cycle ops (AND, OR, ADD, SUB, SLL, NOR, SLT, undefined codes) finish
// one cycle after accept. MUL is an iterative shift-add multiplier that
// produces the full 2*WIDTH product over WIDTH iterations. When the macro
// SEQ_ALU_DIV_EN is defined, DIV/REM run an iterative unsigned restoring
// divider; otherwise those opcodes behave like undefined opcodes.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   ALUOperation opcode, sampled on accept
//   A, B         operands, sampled on accept
//   InValid      request present
//   InReady      block can accept (only in IDLE)
//   OutValid     result registers valid (DONE state)
//   OutReady     consumer takes the result
//   ALUResult    result (MUL low word, DIV quotient, REM remainder)
//   ALUResultHi  MUL high word, 0 for all other ops
//   Zero         ALUResult == 0, registered with the result
//   DivByZero    DIV/REM with B == 0 (tied 0 without SEQ_ALU_DIV_EN)
module seq_alu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             InValid,
  output logic             InReady,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] ALUResultHi,
  output logic             Zero,
  output logic             DivByZero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_NOR = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  state_t state, state_next;

  // Shared iteration registers. For MUL: opnd = multiplicand, acc_hi = upper
  // product half, shreg = multiplier shifting out LSB-first while the low
  // product half shifts in from the top. For DIV: opnd = divisor,
  // acc_hi = partial remainder, shreg = dividend shifting out MSB-first while
  // quotient bits shift in at the bottom.
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] shreg;
  logic [SHW-1:0]   count;

  logic             accept;
  logic             op_mul;
  logic             op_div;
  logic             shift_big;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;

  assign InReady  = (state == IDLE);
  assign OutValid = (state == DONE);
  assign accept   = InValid && InReady;
  assign op_mul   = (ALUOperation == OP_MUL);

  // Any set bit above the shift-amount field means B >= WIDTH.
  assign shift_big = |B[WIDTH-1:SHW];

  assign mul_sum     = {1'b0, acc_hi} + (shreg[0] ? {1'b0, opnd} : '0);
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], shreg[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIV = 4'b1000;
  localparam logic [3:0] OP_REM = 4'b1001;

  logic             is_rem;
  logic             div_by_zero;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign op_div = (ALUOperation == OP_DIV) || (ALUOperation == OP_REM);

  // Restoring step: bring in the next dividend bit, trial-subtract the
  // divisor, keep the difference only when it did not borrow. A zero divisor
  // never borrows, which yields quotient all-ones and remainder A directly.
  assign div_shift = {acc_hi, shreg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_fits  = ~div_diff[WIDTH];
  assign rem_next  = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_next  = {shreg[WIDTH-2:0], div_fits};
  assign DivByZero = div_by_zero;
`else
  assign op_div    = 1'b0;
  assign DivByZero = 1'b0;
`endif

  // Result of the single-cycle operations for the operands at the input.
  always_comb begin
    single_res = '0;
    case (ALUOperation)
      OP_AND:  single_res = A & B;
      OP_OR:   single_res = A | B;
      OP_ADD:  single_res = A + B;
      OP_SUB:  single_res = A - B;
      OP_SLL:  single_res = shift_big ? '0 : (A << B[SHW-1:0]);
      OP_NOR:  single_res = ~(A | B);
      OP_SLT:  single_res = WIDTH'(A < B);
      default: single_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op_mul) begin
            state_next = MUL_RUN;
          end else if (op_div) begin
            state_next = DIV_RUN;
          end else begin
            state_next = DONE;
          end
        end
      end
      MUL_RUN, DIV_RUN: begin
        if (count == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (OutReady) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registers. The result
  // registers are only written on entry to DONE so the previous result is
  // held through IDLE and the running states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opnd        <= '0;
      acc_hi      <= '0;
      shreg       <= '0;
      count       <= '0;
      ALUResult   <= '0;
      ALUResultHi <= '0;
      Zero        <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      is_rem      <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_mul) begin
              acc_hi <= '0;
              opnd   <= A;
              shreg  <= B;
              count  <= SHW'(WIDTH - 1);
            end
`ifdef SEQ_ALU_DIV_EN
            else if (op_div) begin
              acc_hi <= '0;
              opnd   <= B;
              shreg  <= A;
              count  <= SHW'(WIDTH - 1);
              is_rem <= ALUOperation[0];
            end
`endif
            else begin
              ALUResult   <= single_res;
              ALUResultHi <= '0;
              Zero        <= ~|single_res;
`ifdef SEQ_ALU_DIV_EN
              div_by_zero <= 1'b0;
`endif
            end
          end
        end
        MUL_RUN: begin
          acc_hi <= mul_hi_next;
          shreg  <= mul_lo_next;
          count  <= count - SHW'(1);
          if (count == '0) begin
            ALUResult   <= mul_lo_next;
            ALUResultHi <= mul_hi_next;
            Zero        <= ~|mul_lo_next;
`ifdef SEQ_ALU_DIV_EN
            div_by_zero <= 1'b0;
`endif
          end
        end
`ifdef SEQ_ALU_DIV_EN
        DIV_RUN: begin
          acc_hi <= rem_next;
          shreg  <= quo_next;
          count  <= count - SHW'(1);
          if (count == '0) begin
            ALUResult   <= is_rem ? rem_next : quo_next;
            ALUResultHi <= '0;
            Zero        <= ~|(is_rem ? rem_next : quo_next);
            div_by_zero <= ~|opnd;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard testbench for seq_alu (WIDTH = 32).
//
// The driver pushes a hand-computed expected response into a queue each time
// the DUT accepts a request; an independent monitor pops and compares on every
// output handshake, including the accept-to-OutValid latency. Directed checks
// cover reset, operand hold during MUL, backpressure and mid-operation reset.
// Define SEQ_ALU_DIV_EN for both the DUT and this bench to exercise DIV/REM.
module tb_seq_alu;

  localparam int WIDTH = 32;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        dbz;
    int          lat;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        dbz;
    int          lat;
  } vec_t;

  logic              clk;
  logic              reset;
  logic [3:0]        ALUOperation;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              InValid;
  logic              InReady;
  logic              OutValid;
  logic              OutReady;
  logic [WIDTH-1:0]  ALUResult;
  logic [WIDTH-1:0]  ALUResultHi;
  logic              Zero;
  logic              DivByZero;

  exp_t sb[$];
  vec_t vecs[$];

  int num_compared = 0;
  int num_mismatched = 0;
  int cyc = 0;
  int hs_cyc = -1;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .ALUOperation(ALUOperation),
    .A(A),
    .B(B),
    .InValid(InValid),
    .InReady(InReady),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .ALUResult(ALUResult),
    .ALUResultHi(ALUResultHi),
    .Zero(Zero),
    .DivByZero(DivByZero)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index: the value seen between two rising edges names that cycle.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [31:0] hi,
                        input logic dbz, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b;
    v.res = res; v.hi = hi; v.dbz = dbz; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Call just after a rising edge. Holds the request until the DUT accepts it
  // and records the expected response at the accept cycle.
  task automatic applyStimulus(input string name, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] e_res, input logic [31:0] e_hi,
                               input logic e_dbz, input int e_lat,
                               output int acc_cyc);
    exp_t e;
    bit   done = 0;
    int   waited = 0;
    ALUOperation = op;
    A = a;
    B = b;
    InValid = 1'b1;
    acc_cyc = -1;
    while (!done && waited < 200) begin
      @(negedge clk);
      if (InReady) begin
        acc_cyc = cyc;
        e.name = name; e.res = e_res; e.hi = e_hi; e.zero = (e_res == 32'h0);
        e.dbz = e_dbz; e.lat = e_lat; e.acc_cyc = cyc;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    InValid = 1'b0;
    if (!done) checkOutput({name, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  // Monitor: compares every output handshake against the scoreboard head.
  initial begin
    exp_t e;
    bit   seen = 0;
    int   rise_cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        seen = 0;
      end else begin
        if (OutValid && !seen) begin
          seen = 1;
          rise_cyc = cyc;
        end
        if (OutValid && OutReady) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            checkOutput({e.name, "_result"}, 64'(ALUResult), 64'(e.res));
            checkOutput({e.name, "_hi"}, 64'(ALUResultHi), 64'(e.hi));
            checkOutput({e.name, "_zero"}, 64'(Zero), 64'(e.zero));
            checkOutput({e.name, "_divbyzero"}, 64'(DivByZero), 64'(e.dbz));
            checkOutput({e.name, "_latency"}, 64'(rise_cyc - e.acc_cyc), 64'(e.lat));
          end
          hs_cyc = cyc;
          seen = 0;
        end
      end
    end
  end

  task automatic printSummary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    num_mismatched++;
    printSummary();
    $finish;
  end

  initial begin
    int  acc;
    int  acc2;
    bit  in_ready_low;
    bit  result_held;
    bit  stable;
    int  waited;

    reset = 1'b1;
    InValid = 1'b0;
    OutReady = 1'b1;
    ALUOperation = 4'h0;
    A = '0;
    B = '0;

    // Reset state.
    #12;
    checkOutput("reset_outvalid", 64'(OutValid), 64'd0);
    checkOutput("reset_result", 64'(ALUResult), 64'd0);
    checkOutput("reset_hi", 64'(ALUResultHi), 64'd0);
    checkOutput("reset_zero", 64'(Zero), 64'd0);
    checkOutput("reset_divbyzero", 64'(DivByZero), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_inready", 64'(InReady), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors.
    addVec("and",      4'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1);
    addVec("or",       4'h1, 32'h12340000, 32'h00005678, 32'h12345678, 32'h0, 1'b0, 1);
    addVec("add_wrap", 4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b0, 1);
    addVec("sub_neg",  4'h3, 32'd3,        32'd5,        32'hFFFFFFFE, 32'h0, 1'b0, 1);
    addVec("sub_zero", 4'h3, 32'd9,        32'd9,        32'h00000000, 32'h0, 1'b0, 1);
    addVec("sll_31",   4'h4, 32'd1,        32'd31,       32'h80000000, 32'h0, 1'b0, 1);
    addVec("sll_32",   4'h4, 32'd1,        32'd32,       32'h00000000, 32'h0, 1'b0, 1);
    addVec("sll_big",  4'h4, 32'hFFFFFFFF, 32'h00000100, 32'h00000000, 32'h0, 1'b0, 1);
    addVec("nor",      4'h5, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0, 1'b0, 1);
    addVec("slt_true", 4'h6, 32'd3,        32'd5,        32'h00000001, 32'h0, 1'b0, 1);
    addVec("slt_uns",  4'h6, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h0, 1'b0, 1);
    addVec("undef_a",  4'hA, 32'd5,        32'd6,        32'h00000000, 32'h0, 1'b0, 1);
    addVec("undef_f",  4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b0, 1);
    addVec("mul_small", 4'h7, 32'h12345678, 32'h10,      32'h23456780, 32'h1, 1'b0, 33);
`ifdef SEQ_ALU_DIV_EN
    addVec("div",      4'h8, 32'd100,      32'd7,        32'd14,       32'h0, 1'b0, 33);
    addVec("rem",      4'h9, 32'd100,      32'd7,        32'd2,        32'h0, 1'b0, 33);
    addVec("div_by0",  4'h8, 32'd5,        32'd0,        32'hFFFFFFFF, 32'h0, 1'b1, 33);
    addVec("rem_by0",  4'h9, 32'd5,        32'd0,        32'd5,        32'h0, 1'b1, 33);
    addVec("div_big",  4'h8, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'h0, 1'b0, 33);
`else
    addVec("op8_nodiv", 4'h8, 32'd100,     32'd7,        32'h00000000, 32'h0, 1'b0, 1);
    addVec("op9_nodiv", 4'h9, 32'd100,     32'd7,        32'h00000000, 32'h0, 1'b0, 1);
`endif
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].res, vecs[i].hi, vecs[i].dbz, vecs[i].lat, acc);
    end

    // MUL of the largest operands; previous result 0x42 must be held and
    // InReady must stay low until OutValid.
    applyStimulus("pre_mul", 4'h2, 32'h40, 32'h2, 32'h42, 32'h0, 1'b0, 1, acc);
    applyStimulus("mul_max", 4'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,
                  32'hFFFFFFFE, 1'b0, 33, acc);
    in_ready_low = 1;
    result_held = 1;
    waited = 0;
    while (waited < 60) begin
      @(negedge clk);
      if (OutValid) break;
      if (InReady) in_ready_low = 0;
      if (ALUResult !== 32'h42) result_held = 0;
      waited++;
    end
    checkOutput("mul_inready_low", 64'(in_ready_low), 64'd1);
    checkOutput("mul_result_held", 64'(result_held), 64'd1);
    checkOutput("mul_completed", 64'(waited < 60), 64'd1);
    @(posedge clk);
    #1;

    // Backpressure: ADD completes, consumer stalls 5 cycles while a new
    // request with a different A is held at the input.
    OutReady = 1'b0;
    applyStimulus("bp_add", 4'h2, 32'h10, 32'h20, 32'h30, 32'h0, 1'b0, 1, acc);
    ALUOperation = 4'h2;
    A = 32'h55;
    B = 32'h1;
    InValid = 1'b1;
    stable = 1;
    in_ready_low = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!OutValid || ALUResult !== 32'h30) stable = 0;
      if (InReady) in_ready_low = 0;
      @(posedge clk);
      #1;
    end
    checkOutput("bp_result_stable", 64'(stable), 64'd1);
    checkOutput("bp_no_accept", 64'(in_ready_low), 64'd1);
    OutReady = 1'b1;
    applyStimulus("bp_next", 4'h2, 32'h55, 32'h1, 32'h56, 32'h0, 1'b0, 1, acc2);
    checkOutput("bp_accept_after_handshake", 64'(acc2), 64'(hs_cyc + 1));

    // Reset in the 10th cycle of a MUL aborts it.
    applyStimulus("mul_aborted", 4'h7, 32'h1234, 32'h5678, 32'h0, 32'h0, 1'b0, 33, acc);
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkOutput("abort_outvalid", 64'(OutValid), 64'd0);
    checkOutput("abort_result", 64'(ALUResult), 64'd0);
    checkOutput("abort_hi", 64'(ALUResultHi), 64'd0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_inready", 64'(InReady), 64'd1);
    @(posedge clk);
    #1;
    applyStimulus("add_after_reset", 4'h2, 32'd5, 32'd7, 32'd12, 32'h0, 1'b0, 1, acc);

    // Drain outstanding responses.
    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    checkOutput("drain_scoreboard", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);

    printSummary();
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised multi-cycle successor to the datapath's single-cycle 32-bit ALU.
- Registered result with a valid/ready handshake on input and output.
- Single-cycle logic/arith ops, plus an iterative shift-add multiplier that returns the full double-width product; an optional iterative unsigned divider.
- Sits between the register-file read stage and write-back; the control FSM stalls on InReady/OutValid.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount / iteration-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ALUOperation  input  4  opcode, sampled on accept.
- A  input  WIDTH  operand A, sampled on accept.
- B  input  WIDTH  operand B, sampled on accept.
- InValid  input  1  request present.
- InReady  output  1  block can accept; high only in IDLE.
- OutValid  output  1  result registers valid.
- OutReady  input  1  consumer takes result.
- ALUResult  output  WIDTH  result; MUL low word; DIV quotient; REM remainder.
- ALUResultHi  output  WIDTH  MUL high word; 0 for all other ops.
- Zero  output  1  ALUResult == 0, registered with the result.
- DivByZero  output  1  DIV/REM with B == 0; else 0.

Behaviour:
- Reset (async, active-high): state=IDLE; ALUResult, ALUResultHi, Zero, DivByZero, OutValid = 0; InReady = 1 after reset deasserts. Reset mid-operation aborts it and discards partial results.
- Accept: InValid && InReady at a rising edge; A, B, ALUOperation captured.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD (mod 2^WIDTH); 0011 SUB (mod 2^WIDTH).
  - 0100 SLL: A << B; result 0 when B >= WIDTH.
  - 0101 NOR.
  - 0110 SLT: unsigned A < B gives 1, else 0.
  - 0111 MUL: unsigned, {ALUResultHi, ALUResult} = A*B.
  - 1000 DIV and 1001 REM: see Optional Feature.
  - 1010-1111: result 0, completes as a single-cycle op.
- FSM states are IDLE, MUL_RUN, DIV_RUN and DONE.
  - IDLE, accept of a single-cycle op: result computed and registered; go to DONE.
  - IDLE, accept of MUL: clear accumulator; load counter = WIDTH-1; go to MUL_RUN.
  - MUL_RUN: one multiplier bit per cycle (LSB first, shift-add into a 2*WIDTH accumulator). At counter == 0, register the result and go to DONE.
  - DIV_RUN: one restoring-division step per cycle, WIDTH steps, then go to DONE.
  - DONE: OutValid = 1. Outputs are held stable until OutReady; the cycle OutValid && OutReady is the handshake, then go to IDLE.
- Latency from accept edge to OutValid high:
  - single-cycle ops: 1 cycle.
  - MUL, DIV, REM: WIDTH+1 cycles.
- Throughput: one op at a time. InReady is 0 in MUL_RUN, DIV_RUN and DONE. A new op may be accepted in the cycle after the output handshake.
- Outputs do not change outside DONE entry; the previous result is held through IDLE and RUN states.
- OutReady asserted early (before DONE) has no effect.
- InValid while busy is ignored; the requester must hold it.

Optional Feature:
- Macro SEQ_ALU_DIV_EN.
- Defined:
  - DIV and REM are unsigned restoring divides via DIV_RUN.
  - B == 0 gives quotient all-ones, remainder A, DivByZero = 1, with normal WIDTH+1 latency.
- Undefined:
  - No divider logic; DIV_RUN unreachable.
  - 1000 and 1001 behave as undefined opcodes: result 0, single-cycle.
  - DivByZero tied 0.

Test Plan (WIDTH=32):
- Reset asserted mid-MUL (cycle 10 of 33) -> asynchronously OutValid=0, InReady=1 after release, ALUResult=0; next ADD 5+7 -> 12 one cycle after accept.
- SUB A=3, B=5 -> ALUResult=0xFFFFFFFE, Zero=0; SUB 9-9 -> 0, Zero=1; SLL A=1, B=31 -> 0x80000000; SLL B=32 -> 0.
- MUL A=0xFFFFFFFF, B=0xFFFFFFFF -> ALUResultHi=0xFFFFFFFE, ALUResult=0x00000001, OutValid exactly 33 cycles after accept, InReady=0 throughout.
- Backpressure: ADD done, OutReady low 5 cycles with InValid=1 and a different A -> result stable, no accept; OutReady=1 -> handshake, new op accepted the following cycle.
- DIV_EN defined: DIV 100/7 -> 14; REM -> 2; DIV 5/0 -> 0xFFFFFFFF, DivByZero=1.
- DIV_EN undefined: opcode 1000 -> ALUResult=0, DivByZero=0, one-cycle latency.
